// File: rtl/ucie_ctl_sb_tx_serializer.sv
// Sideband config transmitter: splits each credited MSG_W-bit message into MSG_W/NC beats, MSB chunk first.
// Beat 0 appears the cycle after the handshake; the message parks in WAIT_CRD while no receiver credit is held.
module ucie_ctl_sb_tx_serializer #(
  parameter  int NC      = 8,
  parameter  int MSG_W   = 32,
  parameter  int CRD_MAX = 4,
  localparam int BEATS   = MSG_W / NC,
  localparam int CW      = $clog2(CRD_MAX + 1),
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_msg_vld,
  input  logic [MSG_W-1:0] i_msg,
  output logic             o_msg_rdy,
  input  logic             i_cfg_crd,
  output logic             o_pl_cfg_vld,
  output logic [NC-1:0]    o_pl_cfg,
  output logic [CW-1:0]    o_crd_avail,
  output logic             o_busy,
  output logic             o_crd_overflow
);

  typedef enum logic [1:0] {IDLE, WAIT_CRD, SEND} state_t;

  state_t           state;
  logic [MSG_W-1:0] msg_q;
  logic [BW-1:0]    beat_cnt;
  logic [CW-1:0]    crd;
  logic             hs;
  logic             crd_nz;
  logic             consume;
  logic [BW-1:0]    beat_nxt;
  logic [NC-1:0]    beat_dat;

  assign o_msg_rdy   = (state == IDLE);
  assign hs          = i_msg_vld & o_msg_rdy;
  assign crd_nz      = (crd != '0);
  // A credit is taken exactly once per message, on the cycle that commits to SEND.
  assign consume     = crd_nz & (((state == IDLE) & hs) | (state == WAIT_CRD));
  assign beat_nxt    = beat_cnt + 1'b1;
  assign o_crd_avail = crd;

  always_comb begin
    beat_dat = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_nxt == BW'(k)) beat_dat = msg_q[MSG_W-1-k*NC -: NC];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      msg_q          <= '0;
      beat_cnt       <= '0;
      crd            <= CW'(CRD_MAX);
      o_pl_cfg_vld   <= 1'b0;
      o_pl_cfg       <= '0;
      o_busy         <= 1'b0;
      o_crd_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            msg_q    <= i_msg;
            beat_cnt <= '0;
            o_busy   <= 1'b1;
            if (crd_nz) begin
              state        <= SEND;
              o_pl_cfg_vld <= 1'b1;
              o_pl_cfg     <= i_msg[MSG_W-1 -: NC];
            end else begin
              state <= WAIT_CRD;
            end
          end
        end
        WAIT_CRD: begin
          if (crd_nz) begin
            state        <= SEND;
            o_pl_cfg_vld <= 1'b1;
            o_pl_cfg     <= msg_q[MSG_W-1 -: NC];
          end
        end
        SEND: begin
          if (beat_cnt == BW'(BEATS - 1)) begin
            state        <= IDLE;
            o_pl_cfg_vld <= 1'b0;
            o_busy       <= 1'b0;
          end else begin
            beat_cnt <= beat_nxt;
            o_pl_cfg <= beat_dat;
          end
        end
        default: begin
          state        <= IDLE;
          o_pl_cfg_vld <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase

      // Return and consume in the same cycle cancel; a surplus return at the cap is a receiver fault.
      if (consume && !i_cfg_crd) begin
        crd <= crd - 1'b1;
      end else if (i_cfg_crd && !consume) begin
        if (crd == CW'(CRD_MAX)) o_crd_overflow <= 1'b1;
        else                     crd <= crd + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ucie_ctl_sb_tx_serializer.sv
// Directed bench for the sideband serializer with hand-computed beats and credit counts.
module tb_ucie_ctl_sb_tx_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_vld;
  logic [31:0] msg;
  logic        msg_rdy;
  logic        cfg_crd;
  logic        pl_vld;
  logic [7:0]  pl_cfg;
  logic [2:0]  crd_avail;
  logic        busy;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  ucie_ctl_sb_tx_serializer #(.NC(8), .MSG_W(32), .CRD_MAX(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_msg_vld(msg_vld), .i_msg(msg), .o_msg_rdy(msg_rdy),
    .i_cfg_crd(cfg_crd), .o_pl_cfg_vld(pl_vld), .o_pl_cfg(pl_cfg), .o_crd_avail(crd_avail),
    .o_busy(busy), .o_crd_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; msg_vld = 1'b0; msg = '0; cfg_crd = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // Handshake then run to the next cycle where a new handshake is possible.
  task automatic send_msg(input logic [31:0] m);
    msg_vld = 1'b1; msg = m;
    tick();
    msg_vld = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; msg_vld = 1'b0; msg = '0; cfg_crd = 1'b0;
    tick();
    checks++; if (msg_rdy !== 1'b1)  begin errors++; $display("FAIL reset_rdy got=%b exp=1", msg_rdy); end
    checks++; if (pl_vld !== 1'b0)   begin errors++; $display("FAIL reset_vld got=%b exp=0", pl_vld); end
    checks++; if (pl_cfg !== 8'h00)  begin errors++; $display("FAIL reset_cfg got=%h exp=00", pl_cfg); end
    checks++; if (crd_avail !== 3'd4) begin errors++; $display("FAIL reset_crd got=%0d exp=4", crd_avail); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] exp_b [4];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    msg_vld = 1'b1; msg = 32'hA1B2C3D4;
    tick();
    msg_vld = 1'b0; msg = 32'hDEADBEEF;  // must be ignored outside IDLE
    checks++; if (crd_avail !== 3'd3) begin errors++; $display("FAIL single_crd got=%0d exp=3", crd_avail); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (pl_vld !== 1'b1 || pl_cfg !== exp_b[k])
        begin errors++; $display("FAIL single_beat%0d got vld=%b dat=%h exp vld=1 dat=%h", k, pl_vld, pl_cfg, exp_b[k]); end
      checks++; if (busy !== 1'b1 || msg_rdy !== 1'b0)
        begin errors++; $display("FAIL single_busy%0d got busy=%b rdy=%b exp busy=1 rdy=0", k, busy, msg_rdy); end
      tick();
    end
    checks++; if (pl_vld !== 1'b0 || pl_cfg !== 8'hD4 || msg_rdy !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL single_end got vld=%b dat=%h rdy=%b busy=%b exp 0 D4 1 0", pl_vld, pl_cfg, msg_rdy, busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] msgs [4];
    logic [31:0] m;
    logic [2:0]  exp_crd;
    msgs = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m = msgs[i];
      exp_crd = 3'(3 - i);
      checks++; if (msg_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy%0d got=%b exp=1", i, msg_rdy); end
      msg_vld = 1'b1; msg = m;
      tick();
      msg_vld = 1'b0;
      checks++; if (crd_avail !== exp_crd) begin errors++; $display("FAIL b2b_crd%0d got=%0d exp=%0d", i, crd_avail, exp_crd); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (pl_vld !== 1'b1 || pl_cfg !== m[31-8*k -: 8] || msg_rdy !== 1'b0)
          begin errors++; $display("FAIL b2b_m%0d_beat%0d got vld=%b dat=%h rdy=%b exp 1 %h 0", i, k, pl_vld, pl_cfg, msg_rdy, m[31-8*k -: 8]); end
        tick();
      end
    end
    checks++; if (msg_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy5 got=%b exp=1", msg_rdy); end
    msg_vld = 1'b1; msg = 32'h0F1E2D3C;
    tick();
    msg_vld = 1'b0;
    repeat (2) begin
      checks++; if (pl_vld !== 1'b0 || busy !== 1'b1 || msg_rdy !== 1'b0 || crd_avail !== 3'd0)
        begin errors++; $display("FAIL park got vld=%b busy=%b rdy=%b crd=%0d exp 0 1 0 0", pl_vld, busy, msg_rdy, crd_avail); end
      tick();
    end
  endtask

  task automatic test_credit_release();
    logic [31:0] m;
    m = 32'h0F1E2D3C;
    cfg_crd = 1'b1;
    tick();
    cfg_crd = 1'b0;
    checks++; if (crd_avail !== 3'd1 || pl_vld !== 1'b0)
      begin errors++; $display("FAIL release_c1 got crd=%0d vld=%b exp 1 0", crd_avail, pl_vld); end
    tick();
    checks++; if (crd_avail !== 3'd0) begin errors++; $display("FAIL release_c2_crd got=%0d exp=0", crd_avail); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (pl_vld !== 1'b1 || pl_cfg !== m[31-8*k -: 8])
        begin errors++; $display("FAIL release_beat%0d got vld=%b dat=%h exp 1 %h", k, pl_vld, pl_cfg, m[31-8*k -: 8]); end
      tick();
    end
    checks++; if (pl_vld !== 1'b0 || msg_rdy !== 1'b1)
      begin errors++; $display("FAIL release_end got vld=%b rdy=%b exp 0 1", pl_vld, msg_rdy); end
  endtask

  task automatic test_crd_same_cycle();
    do_reset();
    send_msg(32'h01020304);
    send_msg(32'h05060708);
    checks++; if (crd_avail !== 3'd2) begin errors++; $display("FAIL same_pre got=%0d exp=2", crd_avail); end
    msg_vld = 1'b1; msg = 32'hCAFEF00D; cfg_crd = 1'b1;
    tick();
    msg_vld = 1'b0; cfg_crd = 1'b0;
    checks++; if (crd_avail !== 3'd2 || ovf !== 1'b0 || pl_vld !== 1'b1 || pl_cfg !== 8'hCA)
      begin errors++; $display("FAIL same_cycle got crd=%0d ovf=%b vld=%b dat=%h exp 2 0 1 CA", crd_avail, ovf, pl_vld, pl_cfg); end
    repeat (4) tick();
  endtask

  task automatic test_overflow();
    do_reset();
    cfg_crd = 1'b1;
    tick();
    cfg_crd = 1'b0;
    checks++; if (crd_avail !== 3'd4 || ovf !== 1'b1)
      begin errors++; $display("FAIL ovf_set got crd=%0d ovf=%b exp 4 1", crd_avail, ovf); end
    repeat (3) tick();
    send_msg(32'h12345678);
    checks++; if (ovf !== 1'b1 || crd_avail !== 3'd3)
      begin errors++; $display("FAIL ovf_sticky got ovf=%b crd=%0d exp 1 3", ovf, crd_avail); end
    do_reset();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
  endtask

  task automatic test_reset_mid_msg();
    do_reset();
    msg_vld = 1'b1; msg = 32'hA5B6C7D8;
    tick();
    msg_vld = 1'b0;
    tick();
    tick();
    checks++; if (pl_vld !== 1'b1 || pl_cfg !== 8'hC7)
      begin errors++; $display("FAIL midrst_beat2 got vld=%b dat=%h exp 1 C7", pl_vld, pl_cfg); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pl_vld !== 1'b0 || crd_avail !== 3'd4 || busy !== 1'b0 || msg_rdy !== 1'b1)
      begin errors++; $display("FAIL midrst_async got vld=%b crd=%0d busy=%b rdy=%b exp 0 4 0 1", pl_vld, crd_avail, busy, msg_rdy); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (pl_vld !== 1'b0 || pl_cfg !== 8'h00 || msg_rdy !== 1'b1 || crd_avail !== 3'd4)
        begin errors++; $display("FAIL midrst_after%0d got vld=%b dat=%h rdy=%b crd=%0d exp 0 00 1 4", c, pl_vld, pl_cfg, msg_rdy, crd_avail); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_credit_release();
    test_crd_same_cycle();
    test_overflow();
    test_reset_mid_msg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
